mem_wb_stage: RTL and testbench

- MEM/WB pipeline register with load-data extraction for the 5-stage MIPS core.
- Sits directly downstream of the word-addressed data memory. It takes that memory's combinational 32-bit read word plus the MEM-stage control fields.
- Selects and extends byte/halfword/word load data, chooses the write-back source, and registers the result for the register-file write port and the forwarding network.
- Latency is one cycle. The stage supports stall (hold) and flush (bubble).

---
 rtl/mips_pkg.sv | 25 ++
 rtl/load_ext.sv | 60 ++++++
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared encodings for the 5-stage MIPS core: load-type codes, write-back
// source codes and the default reset PC. No ports; imported by the
// pipeline-stage modules.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Codes 5-7 are reserved and behave as LT_LW.
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    // Code 3 is reserved and behaves as WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/load_ext.sv
// load_ext
// Combinational little-endian load-data extraction. Picks the addressed
// byte/halfword out of the 32-bit memory word and sign- or zero-extends it.
// Ports:
//   dm_rdata  [31:0] in  : word read from data memory
//   addr      [1:0]  in  : low bits of the byte address
//   load_type [2:0]  in  : LW/LB/LBU/LH/LHU (reserved codes act as LW)
//   ext_data  [31:0] out : extracted and extended load value
//   misalign         out : only with MEM_MISALIGN_CHECK_EN defined; the access
//                          is not naturally aligned for its size
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] dm_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic [31:0] ext_data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = dm_rdata[7:0];
        case (addr)
            2'd0: byteSel = dm_rdata[7:0];
            2'd1: byteSel = dm_rdata[15:8];
            2'd2: byteSel = dm_rdata[23:16];
            2'd3: byteSel = dm_rdata[31:24];
            default: byteSel = dm_rdata[7:0];
        endcase

        // addr[0] is deliberately ignored for halfwords (truncation).
        halfSel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        ext_data = dm_rdata;
        case (load_type)
            LT_LB:   ext_data = {{24{byteSel[7]}}, byteSel};
            LT_LBU:  ext_data = {24'd0, byteSel};
            LT_LH:   ext_data = {{16{halfSel[15]}}, halfSel};
            LT_LHU:  ext_data = {16'd0, halfSel};
            default: ext_data = dm_rdata;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (load_type)
            LT_LB, LT_LBU: misalign = 1'b0;
            LT_LH, LT_LHU: misalign = addr[0];
            default:       misalign = (addr != 2'd0);
        endcase
    end
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register. Extracts load data from the combinational
// data-memory word, selects the write-back source and registers the result
// for the register-file write port and the forwarding network.
// Update priority on each rising edge: reset > flush > stall > capture.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misaligned-load detection;
// without it wb_misalign is tied to 0).
// Ports:
//   clk, reset (sync, active-high), stall (hold), flush (bubble)
//   in_valid, pc_in, mem_addr, dm_rdata, alu_result, rd_in, reg_write,
//   wb_sel, load_type                          : MEM-stage inputs
//   wb_valid, wb_pc, wb_rd, wb_we, wb_data,
//   wb_misalign                                : registered WB outputs
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_addr,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_in,
    input  logic        reg_write,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  load_type,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        wb_misalign
);

    logic [31:0] extData;
    logic [31:0] dataCapture;
    logic        weCapture;

    logic        valid_q, valid_d;
    logic [31:0] pc_q,    pc_d;
    logic [4:0]  rd_q,    rd_d;
    logic        we_q,    we_d;
    logic [31:0] data_q,  data_d;

    // Memory is word-addressed; only the byte offset matters here.
    logic unusedAddrBits;
    assign unusedAddrBits = ^mem_addr[31:2];

`ifdef MEM_MISALIGN_CHECK_EN
    logic extMisalign;
    logic misalignCapture;
    logic misalign_q, misalign_d;

    load_ext u_load_ext (
        .dm_rdata  (dm_rdata),
        .addr      (mem_addr[1:0]),
        .load_type (load_type),
        .misalign  (extMisalign),
        .ext_data  (extData)
    );

    // Only real loads that take their result from memory can be misaligned.
    assign misalignCapture = in_valid & (wb_sel == WB_MEM) & extMisalign;
`else
    load_ext u_load_ext (
        .dm_rdata  (dm_rdata),
        .addr      (mem_addr[1:0]),
        .load_type (load_type),
        .ext_data  (extData)
    );
`endif

    always_comb begin
        dataCapture = alu_result;
        case (wb_sel)
            WB_MEM:  dataCapture = extData;
            WB_PC8:  dataCapture = pc_in + 32'd8;
            default: dataCapture = alu_result;
        endcase

        // $zero is never written; bubbles never write.
        weCapture = in_valid & reg_write & (rd_in != 5'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        if (misalignCapture) begin
            weCapture = 1'b0;
        end
`endif
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        we_d    = we_q;
        data_d  = data_q;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        // Flush beats stall so a bubble is inserted even while stalled.
        if (reset || flush) begin
            valid_d = 1'b0;
            pc_d    = RESET_PC;
            rd_d    = 5'd0;
            we_d    = 1'b0;
            data_d  = 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
        end else if (!stall) begin
            valid_d = in_valid;
            pc_d    = pc_in;
            rd_d    = rd_in;
            we_d    = weCapture;
            data_d  = dataCapture;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_d = misalignCapture;
`endif
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        pc_q    <= pc_d;
        rd_q    <= rd_d;
        we_q    <= we_d;
        data_q  <= data_d;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_q <= misalign_d;
`endif
    end

    assign wb_valid = valid_q;
    assign wb_pc    = pc_q;
    assign wb_rd    = rd_q;
    assign wb_we    = we_q;
    assign wb_data  = data_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign wb_misalign = misalign_q;
`else
    assign wb_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed self-checking bench for mem_wb_stage with hand-computed
// expected values. Inputs change #1 after a rising edge; outputs are
// sampled #1 after the following rising edge.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] mem_addr;
    logic [31:0] dm_rdata;
    logic [31:0] alu_result;
    logic [4:0]  rd_in;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        wb_misalign;

    int testCount = 0;
    int failCount = 0;

    mem_wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .pc_in       (pc_in),
        .mem_addr    (mem_addr),
        .dm_rdata    (dm_rdata),
        .alu_result  (alu_result),
        .rd_in       (rd_in),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .load_type   (load_type),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .wb_data     (wb_data),
        .wb_misalign (wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one MEM-stage instruction onto the inputs.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] addr, input logic [31:0] rdata,
                                 input logic [31:0] alu, input logic [4:0] rd,
                                 input logic rw, input logic [1:0] sel,
                                 input logic [2:0] lt);
        in_valid   = v;
        pc_in      = pc;
        mem_addr   = addr;
        dm_rdata   = rdata;
        alu_result = alu;
        rd_in      = rd;
        reg_write  = rw;
        wb_sel     = sel;
        load_type  = lt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"},    {31'd0, wb_valid},    32'd0);
        checkOutput({tag, "_pc"},       wb_pc,                32'h0000_3000);
        checkOutput({tag, "_rd"},       {27'd0, wb_rd},       32'd0);
        checkOutput({tag, "_we"},       {31'd0, wb_we},       32'd0);
        checkOutput({tag, "_data"},     wb_data,              32'd0);
        checkOutput({tag, "_misalign"}, {31'd0, wb_misalign}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 32'h0000_1234, 32'h0, 32'h1111_1111, 32'h2222_2222,
                      5'd3, 1'b1, 2'd0, 3'd0);
        tick();
        checkReset("reset");

        reset = 1'b0;

        // Byte loads from 0x80FF_7F01
        applyStimulus(1'b1, 32'h0000_3000, 32'h0000_0102, 32'h80FF_7F01,
                      32'h0, 5'd4, 1'b1, 2'd1, 3'd1);
        tick();
        checkOutput("lb_addr2", wb_data, 32'hFFFF_FFFF);
        checkOutput("lb_we", {31'd0, wb_we}, 32'd1);
        checkOutput("lb_valid", {31'd0, wb_valid}, 32'd1);
        checkOutput("lb_rd", {27'd0, wb_rd}, 32'd4);
        load_type = 3'd2;
        tick();
        checkOutput("lbu_addr2", wb_data, 32'h0000_00FF);
        load_type = 3'd1; mem_addr = 32'h0000_0101;
        tick();
        checkOutput("lb_addr1", wb_data, 32'h0000_007F);
        mem_addr = 32'h0000_0103;
        tick();
        checkOutput("lb_addr3", wb_data, 32'hFFFF_FF80);
        mem_addr = 32'h0000_0100;
        tick();
        checkOutput("lb_addr0", wb_data, 32'h0000_0001);

        // Halfword and word loads from 0x8001_1234
        applyStimulus(1'b1, 32'h0000_3004, 32'h0000_0202, 32'h8001_1234,
                      32'h0, 5'd6, 1'b1, 2'd1, 3'd3);
        tick();
        checkOutput("lh_hi", wb_data, 32'hFFFF_8001);
        load_type = 3'd4;
        tick();
        checkOutput("lhu_hi", wb_data, 32'h0000_8001);
        load_type = 3'd3; mem_addr = 32'h0000_0200;
        tick();
        checkOutput("lh_lo", wb_data, 32'h0000_1234);
        load_type = 3'd0;
        tick();
        checkOutput("lw", wb_data, 32'h8001_1234);
        load_type = 3'd6;
        tick();
        checkOutput("lt_reserved", wb_data, 32'h8001_1234);

        // Link value, wrap, reserved source, $zero and bubbles
        applyStimulus(1'b1, 32'h0000_3010, 32'h0, 32'h5555_5555, 32'h1234_5678,
                      5'd31, 1'b1, 2'd2, 3'd0);
        tick();
        checkOutput("link", wb_data, 32'h0000_3018);
        checkOutput("link_pc", wb_pc, 32'h0000_3010);
        pc_in = 32'hFFFF_FFFC;
        tick();
        checkOutput("link_wrap", wb_data, 32'h0000_0004);
        wb_sel = 2'd3;
        tick();
        checkOutput("sel_reserved", wb_data, 32'h1234_5678);
        wb_sel = 2'd0; rd_in = 5'd0;
        tick();
        checkOutput("zero_we", {31'd0, wb_we}, 32'd0);
        rd_in = 5'd9; reg_write = 1'b0;
        tick();
        checkOutput("noreg_we", {31'd0, wb_we}, 32'd0);
        reg_write = 1'b1; in_valid = 1'b0;
        tick();
        checkOutput("bubble_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("bubble_we", {31'd0, wb_we}, 32'd0);

        // Capture then stall three cycles with changing inputs
        applyStimulus(1'b1, 32'h0000_0100, 32'h0, 32'h0, 32'hDEAD_BEEF,
                      5'd5, 1'b1, 2'd0, 3'd0);
        tick();
        checkOutput("cap_data", wb_data, 32'hDEAD_BEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'(i[0]), 32'h0000_0200 + i, 32'h0, 32'h0,
                          32'h0BAD_0000 + i, 5'd7, 1'b1, 2'd2, 3'd0);
            tick();
            checkOutput($sformatf("stall%0d_data", i), wb_data, 32'hDEAD_BEEF);
            checkOutput($sformatf("stall%0d_pc", i), wb_pc, 32'h0000_0100);
            checkOutput($sformatf("stall%0d_rd", i), {27'd0, wb_rd}, 32'd5);
            checkOutput($sformatf("stall%0d_we", i), {31'd0, wb_we}, 32'd1);
            checkOutput($sformatf("stall%0d_valid", i), {31'd0, wb_valid}, 32'd1);
        end
        flush = 1'b1;
        tick();
        checkReset("flush_stall");
        flush = 1'b0;
        stall = 1'b0;

        // Reset during a valid LW capture, then resume
        applyStimulus(1'b1, 32'h0000_0400, 32'h0000_0010, 32'hCAFE_F00D,
                      32'h0, 5'd12, 1'b1, 2'd1, 3'd0);
        reset = 1'b1;
        tick();
        checkReset("midreset");
        reset = 1'b0;
        tick();
        checkOutput("resume_data", wb_data, 32'hCAFE_F00D);
        checkOutput("resume_pc", wb_pc, 32'h0000_0400);
        checkOutput("resume_valid", {31'd0, wb_valid}, 32'd1);
        checkOutput("resume_we", {31'd0, wb_we}, 32'd1);

        // Misaligned addresses
        applyStimulus(1'b1, 32'h0000_0500, 32'h0000_0006, 32'h8001_1234,
                      32'h0, 5'd8, 1'b1, 2'd1, 3'd0);
        tick();
        checkOutput("lw6_data", wb_data, 32'h8001_1234);
`ifdef MEM_MISALIGN_CHECK_EN
        checkOutput("lw6_misalign", {31'd0, wb_misalign}, 32'd1);
        checkOutput("lw6_we", {31'd0, wb_we}, 32'd0);
`else
        checkOutput("lw6_misalign", {31'd0, wb_misalign}, 32'd0);
        checkOutput("lw6_we", {31'd0, wb_we}, 32'd1);
`endif
        load_type = 3'd3;
        tick();
        checkOutput("lh6_data", wb_data, 32'hFFFF_8001);
        checkOutput("lh6_misalign", {31'd0, wb_misalign}, 32'd0);
        checkOutput("lh6_we", {31'd0, wb_we}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
